tt_mux_ctrl_driver: RTL and testbench

//  Initiator side of the TinyTapeout mux control interface (ctrl_sel_rst_n / ctrl_sel_inc / ctrl_ena).

---
 rtl/tt_mux_ctrl_driver.sv | 190 +++++++++++++++++++
 tb/tb_tt_mux_ctrl_driver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_mux_ctrl_driver.sv
`default_nettype none
// ============================================================================
// Module   : tt_mux_ctrl_driver
// Purpose  : Initiator for the TinyTapeout mux control interface. On start it
//            drops ena, resets the select counter, increments it addr times
//            and re-asserts ena. All outputs are registered.
// Options  : TT_MUX_CTRL_DRV_SKIP_RESET_EN - when defined, the driver tracks
//            the last selected address. If the new address is at or above it,
//            the counter reset is skipped and only the difference is stepped.
// Revision : 1.0 - initial release
// ============================================================================
module tt_mux_ctrl_driver #(
    parameter int ADDR_W    = 10,
    parameter int PULSE_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DIS   = 3'd1,
        S_RST   = 3'd2,
        S_SET   = 3'd3,
        S_INC_H = 3'd4,
        S_INC_L = 3'd5,
        S_ENA   = 3'd6
    } state_t;

    localparam logic [7:0] C_PHASE_LAST = 8'(PULSE_CYC - 1);

    state_t            state_q, state_d;
    logic [7:0]        phase_q, phase_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rst_n_q, rst_n_d;
    logic              inc_q, inc_d;
    logic              ena_q, ena_d;

    logic              w_phase_end;
    logic [ADDR_W-1:0] w_rem_dec;

`ifdef TT_MUX_CTRL_DRV_SKIP_RESET_EN
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              cur_valid_q, cur_valid_d;
    logic              skip_q, skip_d;
    logic [ADDR_W-1:0] w_skip_rem;

    assign w_skip_rem = tgt_q - cur_addr_q;
`endif

    assign w_phase_end = (phase_q == C_PHASE_LAST);
    assign w_rem_dec   = rem_q - {{(ADDR_W-1){1'b0}}, 1'b1};

    // Next-state, phase counter, step counter and registered-output decode.
    // Outputs are decoded from the current state so every level lasts exactly
    // as many cycles as the state does, delayed by one register stage.
    always_comb begin
        state_d = state_q;
        phase_d = w_phase_end ? 8'd0 : phase_q + 8'd1;
        tgt_d   = tgt_q;
        rem_d   = rem_q;
`ifdef TT_MUX_CTRL_DRV_SKIP_RESET_EN
        cur_addr_d  = cur_addr_q;
        cur_valid_d = cur_valid_q;
        skip_d      = skip_q;
`endif
        case (state_q)
            S_IDLE: begin
                phase_d = 8'd0;
                if (start) begin
                    tgt_d   = addr;
                    state_d = S_DIS;
`ifdef TT_MUX_CTRL_DRV_SKIP_RESET_EN
                    skip_d  = cur_valid_q && (addr >= cur_addr_q);
`endif
                end
            end
            S_DIS: begin
                if (w_phase_end) begin
`ifdef TT_MUX_CTRL_DRV_SKIP_RESET_EN
                    if (skip_q) begin
                        rem_d   = w_skip_rem;
                        state_d = (w_skip_rem == '0) ? S_ENA : S_INC_H;
                    end else begin
                        state_d = S_RST;
                    end
`else
                    state_d = S_RST;
`endif
                end
            end
            S_RST: begin
                if (w_phase_end) state_d = S_SET;
            end
            S_SET: begin
                if (w_phase_end) begin
                    rem_d   = tgt_q;
                    state_d = (tgt_q == '0) ? S_ENA : S_INC_H;
                end
            end
            S_INC_H: begin
                if (w_phase_end) state_d = S_INC_L;
            end
            S_INC_L: begin
                if (w_phase_end) begin
                    rem_d   = w_rem_dec;
                    state_d = (w_rem_dec == '0) ? S_ENA : S_INC_H;
                end
            end
            S_ENA: begin
                phase_d = 8'd0;
                state_d = S_IDLE;
`ifdef TT_MUX_CTRL_DRV_SKIP_RESET_EN
                cur_addr_d  = tgt_q;
                cur_valid_d = 1'b1;
`endif
            end
            default: begin
                phase_d = 8'd0;
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_q == S_IDLE) ? start : (state_q != S_ENA);
        done_d  = (state_q == S_ENA);
        rst_n_d = (state_q != S_RST);
        inc_d   = (state_q == S_INC_H);
        if (state_q == S_ENA)       ena_d = 1'b1;
        else if (state_q == S_IDLE) ena_d = ena_q;
        else                        ena_d = 1'b0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= 8'd0;
            tgt_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rst_n_q <= 1'b1;
            inc_q   <= 1'b0;
            ena_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            tgt_q   <= tgt_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rst_n_q <= rst_n_d;
            inc_q   <= inc_d;
            ena_q   <= ena_d;
        end
    end

`ifdef TT_MUX_CTRL_DRV_SKIP_RESET_EN
    // Last-selected-address tracker; invalid after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr_q  <= '0;
            cur_valid_q <= 1'b0;
            skip_q      <= 1'b0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            cur_valid_q <= cur_valid_d;
            skip_q      <= skip_d;
        end
    end
`endif

    assign busy           = busy_q;
    assign done           = done_q;
    assign ctrl_sel_rst_n = rst_n_q;
    assign ctrl_sel_inc   = inc_q;
    assign ctrl_ena       = ena_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_mux_ctrl_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_mux_ctrl_driver
// Purpose  : Directed self-checking bench for tt_mux_ctrl_driver. Expected
//            sequence shapes are queued when a start is driven and compared
//            when done is observed. Honours TT_MUX_CTRL_DRV_SKIP_RESET_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_mux_ctrl_driver;

    localparam int ADDR_W = 10;
    localparam int P      = 2;
    localparam int MAXC   = 6000;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] addr;
    logic              start;
    logic              busy;
    logic              done;
    logic              ctrl_sel_rst_n;
    logic              ctrl_sel_inc;
    logic              ctrl_ena;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int lat;
        int incs;
        int rstlow;
    } exp_t;

    exp_t sb[$];

    int m_cur   = 0;
    bit m_valid = 0;
    bit mon_en  = 0;
    logic done_prev = 1'b0;

    tt_mux_ctrl_driver #(
        .ADDR_W    (ADDR_W),
        .PULSE_CYC (P)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .addr           (addr),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Protocol invariants checked every cycle once reset has settled.
    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            assert (!(ctrl_sel_inc === 1'b1 && ctrl_sel_rst_n === 1'b0)) else begin
                miscompares++;
                $error("FAIL inc_while_rst: observed inc=%b rst_n=%b, expected never both", ctrl_sel_inc, ctrl_sel_rst_n);
            end
            vectors++;
            assert (!(done === 1'b1 && done_prev === 1'b1)) else begin
                miscompares++;
                $error("FAIL done_width: observed done high 2 cycles, expected 1");
            end
        end
        done_prev = done;
    end

    // Reference model: expected sequence shape for a start of address a.
    task automatic push_exp(input int a);
        exp_t e;
        bit   skip;
        skip = 1'b0;
`ifdef TT_MUX_CTRL_DRV_SKIP_RESET_EN
        skip = m_valid && (a >= m_cur);
`endif
        if (skip) begin
            e.lat    = P + 2*P*(a - m_cur) + 1;
            e.incs   = a - m_cur;
            e.rstlow = 0;
        end else begin
            e.lat    = 3*P + 2*P*a + 1;
            e.incs   = a;
            e.rstlow = P;
        end
        m_cur   = a;
        m_valid = 1'b1;
        sb.push_back(e);
    endtask

    // Called #1 after the start edge; observes until done and compares.
    task automatic measure(input bit repulse);
        exp_t e;
        int k, incs, rstlow, badw, run_hi, run_lo, ena_bad, busy_bad;
        bit got_done, prev_inc, seen_inc;
        k = 0; incs = 0; rstlow = 0; badw = 0; run_hi = 0; run_lo = 0;
        ena_bad = 0; busy_bad = 0; got_done = 1'b0; prev_inc = 1'b0; seen_inc = 1'b0;
        while (!got_done && k < MAXC) begin
            @(posedge clk);
            k++;
            #1;
            if (repulse && k == 5) begin
                addr  = 10'd7;
                start = 1'b1;
            end
            if (repulse && k == 6) start = 1'b0;
            if (ctrl_sel_rst_n === 1'b0) rstlow++;
            if (ctrl_sel_inc === 1'b1 && !prev_inc) begin
                incs++;
                if (seen_inc && run_lo != P) badw++;
                seen_inc = 1'b1;
                run_hi   = 1;
            end else if (ctrl_sel_inc === 1'b0 && prev_inc) begin
                if (run_hi != P) badw++;
                run_lo = 1;
            end else if (ctrl_sel_inc === 1'b1) begin
                run_hi++;
            end else begin
                run_lo++;
            end
            prev_inc = (ctrl_sel_inc === 1'b1);
            got_done = (done === 1'b1);
            if (!got_done) begin
                if (ctrl_ena !== 1'b0) ena_bad++;
                if (busy !== 1'b1) busy_bad++;
            end
        end
        e = sb.pop_front();
        check("latency", k, e.lat);
        check("inc_pulses", incs, e.incs);
        check("rst_low_cycles", rstlow, e.rstlow);
        check("inc_widths", badw, 0);
        check("ena_during_seq", ena_bad, 0);
        check("busy_during_seq", busy_bad, 0);
        check("ena_at_done", {31'd0, ctrl_ena}, 1);
        check("busy_at_done", {31'd0, busy}, 0);
    endtask

    task automatic run(input int a, input bit repulse);
        push_exp(a);
        @(negedge clk);
        addr  = a[ADDR_W-1:0];
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        measure(repulse);
    endtask

    initial begin
        int rises, k;
        reset = 1'b1;
        start = 1'b0;
        addr  = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_sel_rst_n", {31'd0, ctrl_sel_rst_n}, 1);
        check("rst_inc", {31'd0, ctrl_sel_inc}, 0);
        check("rst_ena", {31'd0, ctrl_ena}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Basic sequences and ignored re-start while busy
        run(3, 1'b0);
        run(0, 1'b0);
        check("ena_hold", {31'd0, ctrl_ena}, 1);
        run(2, 1'b1);

        // Reset during the second increment pulse of addr=5
        @(negedge clk);
        addr  = 10'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        rises = 0;
        k = 0;
        while (rises < 2 && k < MAXC) begin
            @(posedge clk);
            k++;
            #1;
            if (ctrl_sel_inc === 1'b1 && k > 0 && rises == 0) rises = 1;
            else if (ctrl_sel_inc === 1'b0 && rises == 1) rises = -1;
            else if (ctrl_sel_inc === 1'b1 && rises == -1) rises = 2;
        end
        check("reach_2nd_pulse", rises, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_inc", {31'd0, ctrl_sel_inc}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_ena", {31'd0, ctrl_ena}, 0);
        check("midrst_rst_n", {31'd0, ctrl_sel_rst_n}, 1);
        reset   = 1'b0;
        m_valid = 1'b0;
        run(1, 1'b0);

        // Widest address: no wrap in the step counter
        run(1023, 1'b0);

        // Back-to-back: start held high across done
        push_exp(3);
        @(negedge clk);
        addr  = 10'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        measure(1'b0);
        addr = 10'd1;
        push_exp(1);
        @(posedge clk);
        #1;
        check("b2b_reaccept_busy", {31'd0, busy}, 1);
        start = 1'b0;
        measure(1'b0);

`ifdef TT_MUX_CTRL_DRV_SKIP_RESET_EN
        // Skip-reset path: up, up (skipped), down (full)
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        m_valid = 1'b0;
        run(4, 1'b0);
        run(6, 1'b0);
        run(2, 1'b0);
        run(2, 1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
